// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state type and forward-select encodings for the hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/forward_sel.sv
// rtl/forward_sel.sv - forward-source select for one Execute operand
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rdm,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] rdw,
    input  logic             reg_write_w,
    output logic [1:0]       fwd
);

    // Memory stage holds the younger result, so it wins over Writeback; x0 is never forwarded
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rdm != '0) && (rdm == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rdw != '0) && (rdw == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, stall/flush, memory-wait FSM and perf counters
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic             ResultSrcE,
    input  logic [REG_W-1:0] RDM,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] RDW,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemBusyM,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Fault,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] LoadUseCount
);

    // Wide enough to hold MEM_TIMEOUT itself
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       lw_stall;
    logic       stall_all;
    logic       bubble;
    logic       br_flush;

    forward_sel #(.REG_W(REG_W)) u_fwd_a (
        .rs          (Rs1E),
        .rdm         (RDM),
        .reg_write_m (RegWriteM),
        .rdw         (RDW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a_raw)
    );

    forward_sel #(.REG_W(REG_W)) u_fwd_b (
        .rs          (Rs2E),
        .rdm         (RDM),
        .reg_write_m (RegWriteM),
        .rdw         (RDW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b_raw)
    );

    assign lw_stall = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Next state, wait count and hazard resolution: busy memory > taken branch > load-use
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        stall_all  = 1'b0;
        bubble     = 1'b0;
        br_flush   = 1'b0;
        case (state)
            RUN: begin
                if (MemBusyM) begin
                    stall_all  = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else if (PCSrcE) begin
                    br_flush = 1'b1;
                end else if (lw_stall) begin
                    bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemBusyM) begin
                    stall_all = 1'b1;
                    wait_next = wait_cnt + WAIT_W'(1);
                    if (wait_next == WAIT_W'(MEM_TIMEOUT)) begin
                        state_next = FAULT;
                    end
                end else begin
                    state_next = RUN;
                    wait_next  = '0;
                    if (PCSrcE) begin
                        br_flush = 1'b1;
                    end else if (lw_stall) begin
                        bubble = 1'b1;
                    end
                end
            end
            FAULT: begin
                stall_all = 1'b1;
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
        if (reset) begin
            stall_all = 1'b0;
            bubble    = 1'b0;
            br_flush  = 1'b0;
        end
    end

    assign ForwardA_E = reset ? FWD_RF : fwd_a_raw;
    assign ForwardB_E = reset ? FWD_RF : fwd_b_raw;
    assign StallF     = stall_all | bubble;
    assign StallD     = stall_all | bubble;
    assign StallE     = stall_all;
    assign StallM     = stall_all;
    assign FlushD     = br_flush;
    assign FlushE     = br_flush | bubble;
    assign Fault      = (state == FAULT);

    // State register and memory-wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount   <= '0;
            FlushCount   <= '0;
            LoadUseCount <= '0;
        end else begin
            if (StallF && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (br_flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
            if (bubble && (LoadUseCount != '1)) begin
                LoadUseCount <= LoadUseCount + CNT_W'(1);
            end
        end
    end

endmodule
